// File: rtl/ace_tape_pkg.sv
// Shared types and default timing for the Jupiter Ace tape playback block.
package ace_tape_pkg;

   localparam int TIMER_W  = 16;
   localparam int LEADER_W = 14;
   localparam int BYTE_W   = 16;
   localparam int BIT_W    = 3;

   // Defaults in clk cycles at 6.5 MHz (2x the Z80 T-state rate).
   localparam int DEF_LEADER_HALF = 4022;
   localparam int DEF_LEADER_HDR  = 8192;
   localparam int DEF_LEADER_DAT  = 1024;
   localparam int DEF_SYNC_HI     = 1202;
   localparam int DEF_SYNC_LO     = 1582;
   localparam int DEF_BIT0_HALF   = 1602;
   localparam int DEF_BIT1_HALF   = 3206;
   localparam int DEF_GAP_LEN     = 65000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEADER,
      ST_SYNC_H,
      ST_SYNC_L,
      ST_DATA,
      ST_WAIT,
      ST_GAP
   } tape_state_e;

   // A level held for n cycles is timed by loading n-1 and running down to 0.
   function automatic logic [TIMER_W-1:0] tm_len(input int n);
      return TIMER_W'(n - 1);
   endfunction

endpackage

// File: rtl/ace_tape_halfperiod.sv
// Loadable down-counter timing one level segment; expire is high while the count is 0.
module ace_tape_halfperiod
   import ace_tape_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               load,
   input  logic [TIMER_W-1:0] len,
   output logic               expire
);

   logic [TIMER_W-1:0] count_q;
   logic [TIMER_W-1:0] count_d;

   // Load takes priority; otherwise count down and park at zero.
   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = len;
      end else if (count_q != '0) begin
         count_d = count_q - TIMER_W'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expire = (count_q == '0);

endmodule

// File: rtl/ace_tape_player.sv
// Tape playback waveform generator feeding the Ace ear input.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | ear low, waiting for start
// LEADER   | square wave of LEADER_HALF halves, selected number of cycles
// SYNC_H   | sync pulse high
// SYNC_L   | sync pulse low, first byte prefetched
// DATA     | bit cells MSB first, high half then low half
// WAIT     | byte boundary reached with nothing held; ear low, underrun set
// GAP      | trailing low time, then done pulse
module ace_tape_player
   import ace_tape_pkg::*;
#(
   parameter int LEADER_HALF = DEF_LEADER_HALF,
   parameter int LEADER_HDR  = DEF_LEADER_HDR,
   parameter int LEADER_DAT  = DEF_LEADER_DAT,
   parameter int SYNC_HI     = DEF_SYNC_HI,
   parameter int SYNC_LO     = DEF_SYNC_LO,
   parameter int BIT0_HALF   = DEF_BIT0_HALF,
   parameter int BIT1_HALF   = DEF_BIT1_HALF,
   parameter int GAP_LEN     = DEF_GAP_LEN
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        is_header,
   input  logic [15:0] block_len,
   input  logic        abort,
   input  logic [7:0]  byte_data,
   input  logic        byte_valid,
   output logic        byte_ready,
   output logic        ear,
   output logic        busy,
   output logic        done,
   output logic        underrun
);

   localparam logic [TIMER_W-1:0]  LH_LEN  = tm_len(LEADER_HALF);
   localparam logic [TIMER_W-1:0]  SH_LEN  = tm_len(SYNC_HI);
   localparam logic [TIMER_W-1:0]  SL_LEN  = tm_len(SYNC_LO);
   localparam logic [TIMER_W-1:0]  B0_LEN  = tm_len(BIT0_HALF);
   localparam logic [TIMER_W-1:0]  B1_LEN  = tm_len(BIT1_HALF);
   localparam logic [TIMER_W-1:0]  GAP_TM  = tm_len(GAP_LEN);
   localparam logic [LEADER_W-1:0] HDR_CNT = LEADER_W'(LEADER_HDR);
   localparam logic [LEADER_W-1:0] DAT_CNT = LEADER_W'(LEADER_DAT);

   tape_state_e         state_q, state_d;
   logic                ear_q, ear_d;
   logic [LEADER_W-1:0] leader_q, leader_d;
   logic [BYTE_W-1:0]   bytes_q, bytes_d;
   logic [BIT_W-1:0]    bit_q, bit_d;
   logic                phase_q, phase_d;
   logic [7:0]          shift_q, shift_d;
   logic [7:0]          hold_q, hold_d;
   logic                hold_vld_q, hold_vld_d;
   logic                underrun_q, underrun_d;
   logic                done_q, done_d;

   logic                tmr_load;
   logic [TIMER_W-1:0]  tmr_len;
   logic                tmr_expire;

   logic                xfer;
   logic                next_avail;
   logic [7:0]          next_byte;
   logic [BIT_W-1:0]    nxt_idx;
   logic                last_byte;
   logic                begin_byte;
   logic [7:0]          begin_val;

   function automatic logic [TIMER_W-1:0] half_len(input logic b);
      return b ? B1_LEN : B0_LEN;
   endfunction

   ace_tape_halfperiod u_half (
      .clk    (clk),
      .reset  (reset),
      .load   (tmr_load),
      .len    (tmr_len),
      .expire (tmr_expire)
   );

   assign xfer       = byte_valid & byte_ready;
   // A byte accepted in the boundary cycle itself is used directly, avoiding a spurious WAIT.
   assign next_avail = hold_vld_q | xfer;
   assign next_byte  = hold_vld_q ? hold_q : byte_data;
   assign nxt_idx    = bit_q - BIT_W'(1);
   assign last_byte  = (bytes_q <= BYTE_W'(1));

   // Stream accept: prefetch windows only while the holding register is empty; abort masks it.
   always_comb begin
      byte_ready = 1'b0;
      case (state_q)
         ST_SYNC_L: byte_ready = !hold_vld_q;
         ST_DATA:   byte_ready = (bit_q == '0) && !last_byte && !hold_vld_q;
         ST_WAIT:   byte_ready = 1'b1;
         default:   byte_ready = 1'b0;
      endcase
      if (abort) begin
         byte_ready = 1'b0;
      end
   end

   // Next-state, waveform level and timer reload.
   always_comb begin
      state_d    = state_q;
      ear_d      = ear_q;
      leader_d   = leader_q;
      bytes_d    = bytes_q;
      bit_d      = bit_q;
      phase_d    = phase_q;
      shift_d    = shift_q;
      hold_d     = hold_q;
      hold_vld_d = hold_vld_q;
      underrun_d = underrun_q;
      done_d     = 1'b0;
      tmr_load   = 1'b0;
      tmr_len    = LH_LEN;
      begin_byte = 1'b0;
      begin_val  = next_byte;

      if (xfer) begin
         hold_d     = byte_data;
         hold_vld_d = 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d    = ST_LEADER;
               ear_d      = 1'b1;
               leader_d   = is_header ? HDR_CNT : DAT_CNT;
               bytes_d    = (block_len == '0) ? BYTE_W'(1) : block_len;
               bit_d      = '0;
               phase_d    = 1'b0;
               hold_vld_d = 1'b0;
               underrun_d = 1'b0;
               tmr_load   = 1'b1;
               tmr_len    = LH_LEN;
            end
         end
         ST_LEADER: begin
            if (tmr_expire) begin
               tmr_load = 1'b1;
               if (ear_q) begin
                  ear_d   = 1'b0;
                  tmr_len = LH_LEN;
               end else if (leader_q <= LEADER_W'(1)) begin
                  state_d = ST_SYNC_H;
                  ear_d   = 1'b1;
                  tmr_len = SH_LEN;
               end else begin
                  leader_d = leader_q - LEADER_W'(1);
                  ear_d    = 1'b1;
                  tmr_len  = LH_LEN;
               end
            end
         end
         ST_SYNC_H: begin
            if (tmr_expire) begin
               state_d  = ST_SYNC_L;
               ear_d    = 1'b0;
               tmr_load = 1'b1;
               tmr_len  = SL_LEN;
            end
         end
         ST_SYNC_L: begin
            if (tmr_expire) begin
               if (next_avail) begin
                  begin_byte = 1'b1;
               end else begin
                  state_d    = ST_WAIT;
                  ear_d      = 1'b0;
                  underrun_d = 1'b1;
               end
            end
         end
         ST_DATA: begin
            if (tmr_expire) begin
               if (!phase_q) begin
                  phase_d  = 1'b1;
                  ear_d    = 1'b0;
                  tmr_load = 1'b1;
                  tmr_len  = half_len(shift_q[bit_q]);
               end else if (bit_q != '0) begin
                  bit_d    = nxt_idx;
                  phase_d  = 1'b0;
                  ear_d    = 1'b1;
                  tmr_load = 1'b1;
                  tmr_len  = half_len(shift_q[nxt_idx]);
               end else if (last_byte) begin
                  state_d  = ST_GAP;
                  ear_d    = 1'b0;
                  tmr_load = 1'b1;
                  tmr_len  = GAP_TM;
               end else begin
                  bytes_d = bytes_q - BYTE_W'(1);
                  if (next_avail) begin
                     begin_byte = 1'b1;
                  end else begin
                     state_d    = ST_WAIT;
                     ear_d      = 1'b0;
                     underrun_d = 1'b1;
                  end
               end
            end
         end
         ST_WAIT: begin
            if (xfer) begin
               begin_byte = 1'b1;
               begin_val  = byte_data;
            end
         end
         ST_GAP: begin
            if (tmr_expire) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            ear_d   = 1'b0;
         end
      endcase

      // Common entry into a byte: consume the byte, first bit's high half.
      if (begin_byte) begin
         state_d    = ST_DATA;
         shift_d    = begin_val;
         hold_vld_d = 1'b0;
         bit_d      = BIT_W'(7);
         phase_d    = 1'b0;
         ear_d      = 1'b1;
         tmr_load   = 1'b1;
         tmr_len    = half_len(begin_val[7]);
      end

      if (abort) begin
         state_d    = ST_IDLE;
         ear_d      = 1'b0;
         hold_vld_d = 1'b0;
         done_d     = 1'b0;
         tmr_load   = 1'b0;
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         ear_q      <= 1'b0;
         leader_q   <= '0;
         bytes_q    <= '0;
         bit_q      <= '0;
         phase_q    <= 1'b0;
         shift_q    <= '0;
         hold_q     <= '0;
         hold_vld_q <= 1'b0;
         underrun_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         ear_q      <= ear_d;
         leader_q   <= leader_d;
         bytes_q    <= bytes_d;
         bit_q      <= bit_d;
         phase_q    <= phase_d;
         shift_q    <= shift_d;
         hold_q     <= hold_d;
         hold_vld_q <= hold_vld_d;
         underrun_q <= underrun_d;
         done_q     <= done_d;
      end
   end

   assign ear      = ear_q;
   assign busy     = (state_q != ST_IDLE);
   assign done     = done_q;
   assign underrun = underrun_q;

endmodule

// File: tb/tb_ace_tape_player.sv
// Self-checking bench for ace_tape_player with shortened tape timings.
module tb_ace_tape_player;

   localparam int LH   = 10;
   localparam int LHDR = 4;
   localparam int LDAT = 2;
   localparam int SH   = 3;
   localparam int SL   = 5;
   localparam int B0   = 2;
   localparam int B1   = 4;
   localparam int GAPL = 20;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        is_header = 1'b0;
   logic [15:0] block_len = 16'd0;
   logic        abort = 1'b0;
   logic [7:0]  byte_data = 8'd0;
   logic        byte_valid = 1'b0;
   logic        byte_ready;
   logic        ear;
   logic        busy;
   logic        done;
   logic        underrun;

   always #5 clk = ~clk;

   ace_tape_player #(
      .LEADER_HALF (LH),
      .LEADER_HDR  (LHDR),
      .LEADER_DAT  (LDAT),
      .SYNC_HI     (SH),
      .SYNC_LO     (SL),
      .BIT0_HALF   (B0),
      .BIT1_HALF   (B1),
      .GAP_LEN     (GAPL)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .is_header  (is_header),
      .block_len  (block_len),
      .abort      (abort),
      .byte_data  (byte_data),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready),
      .ear        (ear),
      .busy       (busy),
      .done       (done),
      .underrun   (underrun)
   );

   typedef struct {
      bit          lvl;
      int          len;
   } run_t;

   typedef struct {
      bit          hdr;
      logic [15:0] len;
      int          nb;
      logic [31:0] data;
      int          stall;
      bit          spur;
      int          exp_leader;
      bit          exp_und;
      bit          exact;
   } vec_t;

   int          n_checks;
   int          n_err;
   vec_t        vecs[5];

   logic [7:0]  src_q[$];
   logic [7:0]  acc_q[$];
   int          acc_cnt;
   int          stall_left;

   bit          cap_lv[$];
   bit          exp_lv[$];
   run_t        cap_r[$];
   run_t        exp_r[$];
   logic [7:0]  dec_bytes[$];
   int          gap_after[$];
   int          dec_leader;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Byte source: presents the queue head, optionally stalls after the first transfer.
   initial begin
      acc_cnt    = 0;
      stall_left = 0;
      forever begin
         @(negedge clk);
         if (src_q.size() > 0 && !(acc_cnt == 1 && stall_left > 0)) begin
            byte_valid = 1'b1;
            byte_data  = src_q[0];
         end else begin
            byte_valid = 1'b0;
         end
         if (acc_cnt == 1 && stall_left > 0) stall_left--;
         #1;
         if (byte_valid && byte_ready) begin
            acc_q.push_back(src_q.pop_front());
            acc_cnt++;
         end
      end
   end

   // Reference waveform straight from the tape format description.
   task automatic build_model(input bit hdr, input int nb, input logic [31:0] data);
      logic [7:0] b;
      int h;
      exp_lv.delete();
      for (int c = 0; c < (hdr ? LHDR : LDAT); c++) begin
         repeat (LH) exp_lv.push_back(1'b1);
         repeat (LH) exp_lv.push_back(1'b0);
      end
      repeat (SH) exp_lv.push_back(1'b1);
      repeat (SL) exp_lv.push_back(1'b0);
      for (int k = 0; k < nb; k++) begin
         b = data[31-8*k -: 8];
         for (int i = 7; i >= 0; i--) begin
            h = b[i] ? B1 : B0;
            repeat (h) exp_lv.push_back(1'b1);
            repeat (h) exp_lv.push_back(1'b0);
         end
      end
      repeat (GAPL) exp_lv.push_back(1'b0);
   endtask

   task automatic build_runs(input bit which);
      run_t cur;
      bit   lv;
      int   n;
      n = which ? exp_lv.size() : cap_lv.size();
      if (which) exp_r.delete(); else cap_r.delete();
      cur.lvl = 1'b0;
      cur.len = 0;
      for (int k = 0; k < n; k++) begin
         lv = which ? exp_lv[k] : cap_lv[k];
         if (cur.len > 0 && lv == cur.lvl) begin
            cur.len++;
         end else begin
            if (cur.len > 0) begin
               if (which) exp_r.push_back(cur); else cap_r.push_back(cur);
            end
            cur.lvl = lv;
            cur.len = 1;
         end
      end
      if (cur.len > 0) begin
         if (which) exp_r.push_back(cur); else cap_r.push_back(cur);
      end
   endtask

   // Tape decoder: count leader cycles, skip sync, read bits from high-half widths.
   task automatic decode();
      int i;
      int nbits;
      logic [7:0] acc;
      build_runs(1'b0);
      dec_leader = 0;
      dec_bytes.delete();
      gap_after.delete();
      i = 0;
      while (i + 1 < cap_r.size() && cap_r[i].len == LH && cap_r[i+1].len == LH) begin
         dec_leader++;
         i += 2;
      end
      check("sync_hi", (i < cap_r.size()) ? cap_r[i].len : -1, SH);
      check("sync_lo", (i + 1 < cap_r.size()) ? cap_r[i+1].len : -1, SL);
      nbits = 0;
      acc   = 8'd0;
      for (int k = i + 2; k < cap_r.size(); k++) begin
         if (cap_r[k].lvl) begin
            acc = {acc[6:0], (cap_r[k].len == B1)};
            nbits++;
            if (nbits == 8) begin
               dec_bytes.push_back(acc);
               gap_after.push_back((k + 1 < cap_r.size()) ? cap_r[k+1].len : 0);
               nbits = 0;
            end
         end
      end
   endtask

   task automatic run_block(input vec_t v);
      int done_cyc;
      int busy_lost;
      int n;
      @(negedge clk);
      #2;
      src_q.delete();
      acc_q.delete();
      acc_cnt    = 0;
      stall_left = v.stall;
      for (int k = 0; k < v.nb; k++) src_q.push_back(v.data[31-8*k -: 8]);
      src_q.push_back(8'hEE);
      src_q.push_back(8'hEE);
      is_header = v.hdr;
      block_len = v.len;
      start     = 1'b1;
      cap_lv.delete();
      done_cyc  = 0;
      busy_lost = 0;
      @(negedge clk);
      start = 1'b0;
      check("ear_rise", int'(ear), 1);
      check("busy_rise", int'(busy), 1);
      check("underrun_clr", int'(underrun), 0);
      for (int c = 1; c < 3000; c++) begin
         if (c > 1) @(negedge clk);
         if (v.spur && c == 5) begin
            start     = 1'b1;
            is_header = ~v.hdr;
            block_len = 16'd4;
         end else begin
            start = 1'b0;
         end
         if (done) begin
            done_cyc = c;
            break;
         end
         if (!busy) busy_lost++;
         cap_lv.push_back(ear);
      end
      start = 1'b0;
      check("done_seen", int'(done_cyc != 0), 1);
      check("busy_hold", busy_lost, 0);
      check("done_busy", int'(busy), 0);
      check("done_ear", int'(ear), 0);
      check("underrun", int'(underrun), int'(v.exp_und));
      @(negedge clk);
      check("done_width", int'(done), 0);
      check("accepted", acc_q.size(), v.nb);
      n = (acc_q.size() < v.nb) ? acc_q.size() : v.nb;
      for (int k = 0; k < n; k++)
         check($sformatf("acc_byte%0d", k), int'(acc_q[k]), int'(v.data[31-8*k -: 8]));
      decode();
      check("leader", dec_leader, v.exp_leader);
      check("dec_count", dec_bytes.size(), v.nb);
      n = (dec_bytes.size() < v.nb) ? dec_bytes.size() : v.nb;
      for (int k = 0; k < n; k++)
         check($sformatf("dec_byte%0d", k), int'(dec_bytes[k]), int'(v.data[31-8*k -: 8]));
      if (v.stall > 0 && gap_after.size() > 0)
         check("stall_low", int'(gap_after[0] > B1 + 4), 1);
      if (v.exact) begin
         build_model(v.hdr, v.nb, v.data);
         check("done_cycle", done_cyc, exp_lv.size() + 1);
         build_runs(1'b1);
         check("run_count", cap_r.size(), exp_r.size());
         n = (cap_r.size() < exp_r.size()) ? cap_r.size() : exp_r.size();
         for (int k = 0; k < n; k++)
            check($sformatf("run%0d_len", k), cap_r[k].len, exp_r[k].len);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t rv;
      int   dseen;
      n_checks = 0;
      n_err    = 0;
      //          hdr   len     nb data          stall spur leader und  exact
      vecs[0] = '{1'b1, 16'd1, 1, 32'hA5000000, 0,  1'b0, LHDR, 1'b0, 1'b1};
      vecs[1] = '{1'b0, 16'd3, 3, 32'h00FF8100, 0,  1'b0, LDAT, 1'b0, 1'b1};
      vecs[2] = '{1'b0, 16'd2, 2, 32'h00810000, 50, 1'b0, LDAT, 1'b1, 1'b0};
      vecs[3] = '{1'b1, 16'd0, 1, 32'h3C000000, 0,  1'b0, LHDR, 1'b0, 1'b1};
      vecs[4] = '{1'b0, 16'd1, 1, 32'h5A000000, 0,  1'b1, LDAT, 1'b0, 1'b1};

      reset = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_ear", int'(ear), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_ready", int'(byte_ready), 0);
      check("rst_underrun", int'(underrun), 0);
      reset = 1'b1;

      foreach (vecs[i]) run_block(vecs[i]);

      for (int r = 0; r < 6; r++) begin
         rv.hdr        = 1'($urandom_range(0, 1));
         rv.len        = 16'($urandom_range(1, 4));
         rv.nb         = int'(rv.len);
         rv.data       = $urandom;
         rv.stall      = 0;
         rv.spur       = 1'b0;
         rv.exp_leader = rv.hdr ? LHDR : LDAT;
         rv.exp_und    = 1'b0;
         rv.exact      = 1'b1;
         run_block(rv);
      end

      // Abort mid-DATA with a byte prefetched into the holding register.
      @(negedge clk);
      #2;
      src_q.delete();
      acc_q.delete();
      acc_cnt    = 0;
      stall_left = 0;
      src_q.push_back(8'h00);
      src_q.push_back(8'h11);
      src_q.push_back(8'h22);
      is_header = 1'b0;
      block_len = 16'd3;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 300 && acc_cnt < 2; c++) begin
         @(negedge clk);
         #2;
      end
      check("abort_prefetch", acc_cnt, 2);
      @(negedge clk);
      #2;
      abort = 1'b1;
      @(negedge clk);
      check("abort_ear", int'(ear), 0);
      check("abort_busy", int'(busy), 0);
      abort = 1'b0;
      dseen = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) dseen = 1;
      end
      check("abort_no_done", dseen, 0);
      run_block('{1'b0, 16'd1, 1, 32'hC3000000, 0, 1'b0, LDAT, 1'b0, 1'b1});

      // start and abort together in IDLE.
      @(negedge clk);
      #2;
      src_q.delete();
      is_header = 1'b1;
      block_len = 16'd1;
      start     = 1'b1;
      abort     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      check("coll_busy", int'(busy), 0);
      check("coll_ear", int'(ear), 0);
      repeat (5) @(negedge clk);
      check("coll_busy_later", int'(busy), 0);

      // Asynchronous reset during the leader.
      @(negedge clk);
      #2;
      src_q.push_back(8'h77);
      is_header = 1'b1;
      block_len = 16'd1;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (15) @(negedge clk);
      check("pre_rst_busy", int'(busy), 1);
      #2;
      reset = 1'b0;
      #1;
      check("arst_ear", int'(ear), 0);
      check("arst_busy", int'(busy), 0);
      check("arst_done", int'(done), 0);
      check("arst_ready", int'(byte_ready), 0);
      check("arst_underrun", int'(underrun), 0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("arst_idle", int'(busy), 0);
      run_block('{1'b1, 16'd2, 2, 32'h96690000, 0, 1'b0, LHDR, 1'b0, 1'b1});

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
